rv_muldiv: RTL

Parametrised iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the 5-stage pipeline. It sits beside the EX-stage ALU. It takes decoded operands, computes the result over multiple cycles while holding the pipeline stalled, and returns the result with its destination register to the EX/MEM register. Operand width is generic, so the same block serves RV32 and RV64-style datapaths.

---
 rtl/rv_muldiv.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rv_muldiv.sv
// rv_muldiv: RV32M multiply/divide unit beside the EX-stage ALU, one result bit per cycle.
// Define RV_MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle product.
module rv_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;

  state_t            r_state;
  logic [1:0]        r_fsel;
  logic [4:0]        r_rd_pend;
  logic [4:0]        r_rd;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opb;
  logic [XLEN-1:0]   r_result;
  logic              r_neg;

  logic              w_accept;
  logic              w_is_div;
  logic              w_s1_signed, w_s2_signed;
  logic              w_s1_neg, w_s2_neg;
  logic [XLEN-1:0]   w_mag1, w_mag2;
  logic              w_div_zero, w_div_ovf;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN:0]     w_div_trial;
  logic              w_div_ge;
  logic [2*XLEN-1:0] w_div_next;
  logic [XLEN-1:0]   w_div_raw, w_div_res;

  assign o_ready  = (r_state == S_IDLE) && !rst;
  assign o_busy   = (r_state == S_MUL) || (r_state == S_DIV);
  assign o_valid  = (r_state == S_DONE);
  assign o_result = r_result;
  assign o_rd     = r_rd;

  assign w_accept    = i_valid && o_ready && !i_flush;
  assign w_is_div    = i_funct3[2];
  // MULHSU (2) treats only rs1 as signed; MUL's low half is sign-agnostic.
  assign w_s1_signed = w_is_div ? !i_funct3[0] : (i_funct3[1:0] == 2'b01 || i_funct3[1:0] == 2'b10);
  assign w_s2_signed = w_is_div ? !i_funct3[0] : (i_funct3[1:0] == 2'b01);
  assign w_s1_neg    = w_s1_signed && i_rs1[XLEN-1];
  assign w_s2_neg    = w_s2_signed && i_rs2[XLEN-1];
  assign w_mag1      = w_s1_neg ? -i_rs1 : i_rs1;
  assign w_mag2      = w_s2_neg ? -i_rs2 : i_rs2;

  assign w_div_zero    = (i_rs2 == '0);
  assign w_div_ovf     = !i_funct3[0] && (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2 == '1);
  assign w_special_res = w_div_zero ? (i_funct3[1] ? i_rs1 : '1)
                                    : (i_funct3[1] ? '0 : i_rs1);

  // Restoring step: remainder lives in the upper half, dividend/quotient shifts through the lower.
  assign w_div_trial = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]} - {1'b0, r_opb};
  assign w_div_ge    = !w_div_trial[XLEN];
  assign w_div_next  = {(w_div_ge ? w_div_trial[XLEN-1:0] : {r_acc[2*XLEN-2:XLEN], r_acc[XLEN-1]}),
                        r_acc[XLEN-2:0], w_div_ge};
  assign w_div_raw   = r_fsel[1] ? w_div_next[2*XLEN-1:XLEN] : w_div_next[XLEN-1:0];
  assign w_div_res   = r_neg ? -w_div_raw : w_div_raw;

`ifdef RV_MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] w_fa, w_fb, w_fprod;
  logic [XLEN-1:0]          w_fast_res;

  assign w_fa       = {{XLEN{w_s1_signed && i_rs1[XLEN-1]}}, i_rs1};
  assign w_fb       = {{XLEN{w_s2_signed && i_rs2[XLEN-1]}}, i_rs2};
  assign w_fprod    = w_fa * w_fb;
  assign w_fast_res = (i_funct3[1:0] == 2'b00) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`else
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next, w_mul_prod;
  logic [XLEN-1:0]   w_mul_res;

  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
  assign w_mul_prod = r_neg ? -w_mul_next : w_mul_next;
  assign w_mul_res  = (r_fsel == 2'b00) ? w_mul_prod[XLEN-1:0] : w_mul_prod[2*XLEN-1:XLEN];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_fsel    <= '0;
      r_rd_pend <= '0;
      r_rd      <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opb     <= '0;
      r_result  <= '0;
      r_neg     <= 1'b0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_fsel    <= i_funct3[1:0];
            r_rd_pend <= i_rd;
            r_cnt     <= CNT_W'(XLEN - 1);
            if (w_is_div) begin
              r_neg <= w_s1_neg ^ (w_s2_neg && !i_funct3[1]);
              r_opb <= w_mag2;
              r_acc <= {{XLEN{1'b0}}, w_mag1};
              if (w_div_zero || w_div_ovf) begin
                r_result <= w_special_res;
                r_rd     <= i_rd;
                r_state  <= S_DONE;
              end else begin
                r_state <= S_DIV;
              end
            end else begin
`ifdef RV_MULDIV_FAST_MUL_EN
              r_result <= w_fast_res;
              r_rd     <= i_rd;
              r_state  <= S_DONE;
`else
              r_neg   <= w_s1_neg ^ w_s2_neg;
              r_opb   <= w_mag1;
              r_acc   <= {{XLEN{1'b0}}, w_mag2};
              r_state <= S_MUL;
`endif
            end
          end
        end
        S_MUL: begin
`ifdef RV_MULDIV_FAST_MUL_EN
          r_state <= S_IDLE;
`else
          r_acc <= w_mul_next;
          if (r_cnt == '0) begin
            r_result <= w_mul_res;
            r_rd     <= r_rd_pend;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
`endif
        end
        S_DIV: begin
          r_acc <= w_div_next;
          if (r_cnt == '0) begin
            r_result <= w_div_res;
            r_rd     <= r_rd_pend;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
